// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seq_gen_pkg
// Description : Shared defaults for the user sequence generator: default
//               entry width, table depth, the 4-bit Johnson table and the
//               index-width helper (clog2 with a 1-bit minimum).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;

  // Entry i lives at bits [i*WIDTH +: WIDTH]; entry 0 is the rightmost nibble.
  // Walk order: 0 -> 1 -> 3 -> 7 -> F -> E -> C -> 8
  localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] DEF_SEQ =
    {4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

  // Index register width; a single-slot table still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage : seq_gen_pkg
`default_nettype wire

// File: rtl/seq_table_rom.sv
`default_nettype none
// ============================================================================
// Module      : seq_table_rom
// Description : Combinational lookup of one entry from the packed sequence
//               table. Addresses at or beyond LEN return entry 0 so the
//               unused tail of the table can never leak onto the output.
// Ports       : addr_i  [AW-1:0]     entry index
//               data_o  [WIDTH-1:0]  selected entry
// Revision    : 1.0 - initial release
// ============================================================================
module seq_table_rom
  import seq_gen_pkg::*;
#(
  parameter int                         WIDTH = DEF_WIDTH,
  parameter int                         DEPTH = DEF_DEPTH,
  parameter int                         LEN   = DEF_DEPTH,
  parameter int                         AW    = idx_width(DEF_DEPTH),
  parameter logic [DEPTH*WIDTH-1:0]     SEQ   = DEF_SEQ
) (
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = SEQ[WIDTH-1:0];
    for (int i = 0; i < LEN; i++) begin
      if (addr_i == AW'(i)) begin
        data_o = SEQ[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule : seq_table_rom
`default_nettype wire

// File: rtl/user_sequence_design.sv
`default_nettype none
// ============================================================================
// Module      : user_sequence_design
// Description : Free-running programmable sequence generator. Steps through
//               the first LEN entries of SEQ, one entry per enabled clock,
//               wrapping from entry LEN-1 straight back to entry 0.
// Ports       : clk  in   1      rising-edge clock
//               rst  in   1      synchronous reset, active low
//               en   in   1      advance enable
//               c    out  WIDTH  current entry, registered
// Revision    : 1.0 - initial release
// ============================================================================
module user_sequence_design
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN   = DEF_DEPTH,
  parameter     SEQ   = DEF_SEQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] c
);

  localparam int AW = idx_width(DEPTH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_chk_width
    $error("user_sequence_design: WIDTH must be >= 1");
  end
  if (LEN < 2 || LEN > DEPTH) begin : g_chk_len
    $error("user_sequence_design: LEN must satisfy 2 <= LEN <= DEPTH");
  end
  if ($bits(SEQ) != DEPTH*WIDTH) begin : g_chk_seq
    $error("user_sequence_design: SEQ width must equal DEPTH*WIDTH");
  end

  localparam logic [DEPTH*WIDTH-1:0] C_SEQ = SEQ;

  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    idx_d;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] c_q;

  // Next index with wrap: LEN-1 goes straight to 0, no gap and no repeat.
  always_comb begin
    idx_d = idx_q + 1'b1;
    if (idx_q == AW'(LEN - 1)) begin
      idx_d = '0;
    end
  end

  // While reset is asserted the ROM is pointed at entry 0 so the same
  // lookup serves both the reset load and the normal advance.
  assign rom_addr = rst ? idx_d : '0;

  seq_table_rom #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LEN   (LEN),
    .AW    (AW),
    .SEQ   (C_SEQ)
  ) u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Reset wins over enable; the entry for the new index is loaded on the
  // same edge that advances the index, so c carries no extra latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      c_q   <= rom_data;
    end else if (en) begin
      idx_q <= idx_d;
      c_q   <= rom_data;
    end
  end

  assign c = c_q;

endmodule : user_sequence_design
`default_nettype wire

// File: tb/tb_user_sequence_design.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_sequence_design
// Description : Directed bench for user_sequence_design. Three instances:
//               default Johnson table (LEN=8), the same table cut to LEN=5,
//               and a 4-entry custom table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_sequence_design;

  logic       clk;
  logic       rst_a, en_a;
  logic       rst_b, en_b;
  logic       rst_c, en_c;
  logic [3:0] c_a, c_b, c_c;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  user_sequence_design dut_a (
    .clk (clk), .rst (rst_a), .en (en_a), .c (c_a)
  );

  user_sequence_design #(
    .LEN (5)
  ) dut_b (
    .clk (clk), .rst (rst_b), .en (en_b), .c (c_b)
  );

  user_sequence_design #(
    .WIDTH (4),
    .DEPTH (4),
    .LEN   (4),
    .SEQ   ({4'h9, 4'h5, 4'hA, 4'h2})
  ) dut_c (
    .clk (clk), .rst (rst_c), .en (en_c), .c (c_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample one time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_run  [9];
    logic [3:0] exp_short[6];
    logic [3:0] exp_cust [5];
    exp_run   = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
    exp_short = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0, 4'h1};
    exp_cust  = '{4'hA, 4'h5, 4'h9, 4'h2, 4'hA};

    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;

    // Reset with en=1: two edges, entry 0 and index 0 after each.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("reset_c_%0d", i), {4'h0, c_a}, 8'h00);
      chk($sformatf("reset_idx_%0d", i), {5'h0, dut_a.idx_q}, 8'h00);
    end

    // Full run including wrap 8 -> 0 -> 1.
    rst_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("run_%0d", i), {4'h0, c_a}, {4'h0, exp_run[i]});
    end
    chk("run_idx_after_wrap", {5'h0, dut_a.idx_q}, 8'h01);

    // Advance to 7, then hold for 5 edges.
    tick(); chk("pre_hold_3", {4'h0, c_a}, 8'h03);
    tick(); chk("pre_hold_7", {4'h0, c_a}, 8'h07);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), {4'h0, c_a}, 8'h07);
    end
    en_a = 1'b1;
    tick(); chk("resume_F", {4'h0, c_a}, 8'h0F);
    tick(); chk("resume_E", {4'h0, c_a}, 8'h0E);

    // Reset mid-sequence with en held high.
    rst_a = 1'b0;
    tick(); chk("mid_reset_c", {4'h0, c_a}, 8'h00);
    chk("mid_reset_idx", {5'h0, dut_a.idx_q}, 8'h00);
    rst_a = 1'b1;
    tick(); chk("after_mid_reset", {4'h0, c_a}, 8'h01);

    // Reset while en=0 also loads entry 0.
    rst_a = 1'b0; en_a = 1'b0;
    tick(); chk("reset_en0", {4'h0, c_a}, 8'h00);

    // Short LEN=5: C and 8 must never appear.
    rst_b = 1'b1; en_b = 1'b1;
    chk("short_reset", {4'h0, c_b}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("short_%0d", i), {4'h0, c_b}, {4'h0, exp_short[i]});
    end

    // Custom 4-entry table: entry 0 is 2.
    chk("cust_reset", {4'h0, c_c}, 8'h02);
    rst_c = 1'b1; en_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("cust_%0d", i), {4'h0, c_c}, {4'h0, exp_cust[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_user_sequence_design
`default_nettype wire
